// File: rtl/heap_enque_arbiter.sv
// Round-robin arbiter sharing the single heap enque port among NUM_CLIENTS producers.
// One holding register feeds the heap; issue is gated on heap init and occupancy headroom.
module heap_enque_arbiter #(
  parameter  int NUM_CLIENTS            = 4,
  parameter  int HEAP_BITMAP_WIDTH      = 32,
  parameter  int HEAP_MAX_NUM_ENTRIES   = 128,
  parameter  int HEAP_ENTRY_VALUE_WIDTH = 64,
  parameter  int HEAP_SIZE_HEADROOM     = 2,
  localparam int PAW = $clog2(HEAP_BITMAP_WIDTH ** 2),
  localparam int SAW = $clog2(HEAP_MAX_NUM_ENTRIES) + 1,
  localparam int CW  = $clog2(NUM_CLIENTS),
  localparam int W   = HEAP_ENTRY_VALUE_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CLIENTS-1:0]   in_req_valid,
  output logic [NUM_CLIENTS-1:0]   in_req_ready,
  input  logic [NUM_CLIENTS*W-1:0] in_req_value,
  input  logic [NUM_CLIENTS*PAW-1:0] in_req_priority,
  output logic                     out_enque_en,
  input  logic                     in_enque_ready,
  output logic [W-1:0]             out_enque_value,
  output logic [PAW-1:0]           out_enque_priority,
  output logic [CW-1:0]            out_enque_client,
  input  logic [SAW-1:0]           heap_size,
  input  logic                     heap_ready,
  output logic [31:0]              out_enque_count
);

  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;
  localparam logic [SAW:0] SIZE_LIMIT = (SAW+1)'(HEAP_MAX_NUM_ENTRIES - HEAP_SIZE_HEADROOM);

  logic           r_state;
  logic           r_hold_valid;
  logic [W-1:0]   r_value;
  logic [PAW-1:0] r_priority;
  logic [CW-1:0]  r_client;
  logic [CW-1:0]  r_rr_ptr;
  logic [31:0]    r_count;

  logic           w_space_ok;
  logic           w_fire;
  logic           w_load_en;
  logic           w_accept;
  logic           w_grant_found;
  logic [CW-1:0]  w_grant_idx;
  logic [CW:0]    w_scan;
  logic [W-1:0]   w_sel_value;
  logic [PAW-1:0] w_sel_priority;

  assign w_space_ok = ({1'b0, heap_size} < SIZE_LIMIT);
  assign w_fire     = r_hold_valid & in_enque_ready & w_space_ok & (r_state == ST_RUN);
  assign w_load_en  = (r_state == ST_RUN) & (~r_hold_valid | w_fire);
  assign w_accept   = w_load_en & w_grant_found;

  // Scan starts one past the last grant; sum is at most 2N-1 so one subtraction wraps it.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    w_scan        = '0;
    for (int unsigned k = 1; k <= NUM_CLIENTS; k++) begin
      w_scan = {1'b0, r_rr_ptr} + (CW+1)'(k);
      if (w_scan >= (CW+1)'(NUM_CLIENTS))
        w_scan = w_scan - (CW+1)'(NUM_CLIENTS);
      if (!w_grant_found && in_req_valid[w_scan[CW-1:0]]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = w_scan[CW-1:0];
      end
    end
  end

  always_comb begin
    w_sel_value    = '0;
    w_sel_priority = '0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      if (w_grant_idx == CW'(i)) begin
        w_sel_value    = in_req_value[i*W +: W];
        w_sel_priority = in_req_priority[i*PAW +: PAW];
      end
    end
  end

  always_comb begin
    in_req_ready = '0;
    if (w_accept)
      in_req_ready[w_grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_INIT;
      r_hold_valid <= 1'b0;
      r_value      <= '0;
      r_priority   <= '0;
      r_client     <= '0;
      r_rr_ptr     <= CW'(NUM_CLIENTS - 1);
      r_count      <= '0;
    end else begin
      if (r_state == ST_INIT) begin
        if (heap_ready)
          r_state <= ST_RUN;
      end else if (!heap_ready) begin
        r_state <= ST_INIT;
      end

      if (w_fire)
        r_count <= r_count + 32'd1;

      // A new accept overwrites the entry being issued in the same edge.
      if (w_accept) begin
        r_hold_valid <= 1'b1;
        r_value      <= w_sel_value;
        r_priority   <= w_sel_priority;
        r_client     <= w_grant_idx;
        r_rr_ptr     <= w_grant_idx;
      end else if (w_fire) begin
        r_hold_valid <= 1'b0;
      end
    end
  end

  assign out_enque_en       = w_fire;
  assign out_enque_value    = r_value;
  assign out_enque_priority = r_priority;
  assign out_enque_client   = r_client;
  assign out_enque_count    = r_count;

endmodule

// File: tb/tb_heap_enque_arbiter.sv
// Self-checking bench for heap_enque_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_heap_enque_arbiter;

  localparam int N    = 4;
  localparam int W    = 64;
  localparam int PAW  = 10;
  localparam int SAW  = 8;
  localparam int CW   = 2;
  localparam int MAXE = 128;
  localparam int HEAD = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       in_req_valid;
  logic [N-1:0]       in_req_ready;
  logic [N*W-1:0]     in_req_value;
  logic [N*PAW-1:0]   in_req_priority;
  logic               out_enque_en;
  logic               in_enque_ready;
  logic [W-1:0]       out_enque_value;
  logic [PAW-1:0]     out_enque_priority;
  logic [CW-1:0]      out_enque_client;
  logic [SAW-1:0]     heap_size;
  logic               heap_ready;
  logic [31:0]        out_enque_count;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  bit             m_run;
  bit             m_held;
  logic [W-1:0]   m_val;
  logic [PAW-1:0] m_pri;
  int             m_cli;
  int             m_last;
  logic [31:0]    m_count;
  bit             e_fire;
  int             e_grant;
  logic [N-1:0]   e_ready;

  always #5 clk = ~clk;

  heap_enque_arbiter #(
    .NUM_CLIENTS(N),
    .HEAP_BITMAP_WIDTH(32),
    .HEAP_MAX_NUM_ENTRIES(MAXE),
    .HEAP_ENTRY_VALUE_WIDTH(W),
    .HEAP_SIZE_HEADROOM(HEAD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_req_valid(in_req_valid),
    .in_req_ready(in_req_ready),
    .in_req_value(in_req_value),
    .in_req_priority(in_req_priority),
    .out_enque_en(out_enque_en),
    .in_enque_ready(in_enque_ready),
    .out_enque_value(out_enque_value),
    .out_enque_priority(out_enque_priority),
    .out_enque_client(out_enque_client),
    .heap_size(heap_size),
    .heap_ready(heap_ready),
    .out_enque_count(out_enque_count)
  );

  task automatic model_reset();
    m_run   = 1'b0;
    m_held  = 1'b0;
    m_val   = '0;
    m_pri   = '0;
    m_cli   = 0;
    m_last  = N - 1;
    m_count = '0;
  endtask

  task automatic model_eval();
    bit can_load;
    e_fire   = m_run && m_held && in_enque_ready && (int'(heap_size) < MAXE - HEAD);
    can_load = m_run && (!m_held || e_fire);
    e_grant  = -1;
    if (can_load) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (e_grant < 0 && in_req_valid[c]) e_grant = c;
      end
    end
    e_ready = '0;
    if (e_grant >= 0) e_ready[e_grant] = 1'b1;
  endtask

  task automatic model_clock();
    if (e_fire) begin
      m_count = m_count + 32'd1;
      m_held  = 1'b0;
    end
    if (e_grant >= 0) begin
      m_held = 1'b1;
      m_val  = in_req_value[e_grant*W +: W];
      m_pri  = in_req_priority[e_grant*PAW +: PAW];
      m_cli  = e_grant;
      m_last = e_grant;
    end
    if (!m_run && heap_ready) m_run = 1'b1;
    else if (m_run && !heap_ready) m_run = 1'b0;
  endtask

  task automatic adv();
    model_eval();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic set_client(input int c, input logic [W-1:0] v, input logic [PAW-1:0] p);
    in_req_value[c*W +: W]       = v;
    in_req_priority[c*PAW +: PAW] = p;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b0;
    in_req_valid = '0;
    heap_ready   = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst             = 1'b0;
    in_req_valid    = '1;
    heap_ready      = 1'b1;
    in_enque_ready  = 1'b1;
    heap_size       = '0;
    in_req_value    = '1;
    in_req_priority = '1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_enque_en !== 1'b0 || in_req_ready !== '0) begin
      n_bad++;
      $display("FAIL reset_ctl: en=%b ready=%b expected 0/0", out_enque_en, in_req_ready);
    end
    n_cmp++;
    if (out_enque_count !== 32'd0 || out_enque_client !== '0) begin
      n_bad++;
      $display("FAIL reset_cnt: count=%0d client=%0d expected 0/0", out_enque_count, out_enque_client);
    end
    n_cmp++;
    if (out_enque_value !== '0 || out_enque_priority !== '0) begin
      n_bad++;
      $display("FAIL reset_data: value=%0h prio=%0h expected 0/0", out_enque_value, out_enque_priority);
    end
    in_req_valid = '0;
    heap_ready   = 1'b0;
    rst          = 1'b1;
  endtask

  task automatic test_init_gate();
    int bad;
    in_req_valid = 4'b0001;
    set_client(0, W'(23), PAW'(1023));
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (in_req_ready !== '0 || out_enque_en !== 1'b0) bad++;
      adv();
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL init_gate: %0d cycles with ready/en active, expected 0", bad);
    end
    heap_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_req_ready !== '0) begin
      n_bad++;
      $display("FAIL init_first_cycle: ready=%b expected 0000", in_req_ready);
    end
    adv();
    #1;
    n_cmp++;
    if (in_req_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL init_accept: ready=%b expected 0001", in_req_ready);
    end
    adv();
    in_req_valid = '0;
    #1;
    n_cmp++;
    if (out_enque_en !== 1'b1 || out_enque_value !== W'(23) ||
        out_enque_priority !== PAW'(1023) || out_enque_client !== 2'd0) begin
      n_bad++;
      $display("FAIL init_issue: en=%b value=%0d prio=%0d client=%0d expected 1/23/1023/0",
               out_enque_en, out_enque_value, out_enque_priority, out_enque_client);
    end
    adv();
  endtask

  task automatic test_round_robin();
    int acc, fires, first, last;
    do_reset();
    heap_ready     = 1'b1;
    in_enque_ready = 1'b1;
    heap_size      = '0;
    for (int c = 0; c < N; c++) set_client(c, W'(c), PAW'($urandom_range(0, 1023)));
    in_req_valid = '1;
    acc = 0; fires = 0; first = -1; last = -1;
    for (int cyc = 0; cyc < 40 && fires < 8; cyc++) begin
      #1;
      model_eval();
      n_cmp++;
      if (in_req_ready !== e_ready || out_enque_en !== e_fire) begin
        n_bad++;
        $display("FAIL rr_ctl: ready=%b en=%b expected %b/%b", in_req_ready, out_enque_en, e_ready, e_fire);
      end
      if (in_req_ready !== '0) acc++;
      if (out_enque_en === 1'b1) begin
        n_cmp++;
        if (out_enque_client !== CW'(fires % N) || out_enque_value !== W'(fires % N)) begin
          n_bad++;
          $display("FAIL rr_order: client=%0d value=%0d expected %0d", out_enque_client, out_enque_value, fires % N);
        end
        if (first < 0) first = cyc;
        last = cyc;
        fires++;
      end
      adv();
      if (acc >= 8) in_req_valid = '0;
    end
    n_cmp++;
    if (fires != 8 || last - first != 7) begin
      n_bad++;
      $display("FAIL rr_cadence: fires=%0d span=%0d expected 8/7", fires, last - first);
    end
    n_cmp++;
    if (out_enque_count !== 32'd8) begin
      n_bad++;
      $display("FAIL rr_count: count=%0d expected 8", out_enque_count);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    in_enque_ready = 1'b0;
    in_req_valid   = 4'b0010;
    set_client(1, W'(7), PAW'(5));
    #1;
    n_cmp++;
    if (in_req_ready !== 4'b0010) begin
      n_bad++;
      $display("FAIL bp_accept: ready=%b expected 0010", in_req_ready);
    end
    adv();
    for (int c = 0; c < N; c++) set_client(c, W'(100 + c), PAW'(c));
    in_req_valid = '1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (out_enque_en !== 1'b0 || in_req_ready !== '0 ||
          out_enque_value !== W'(7) || out_enque_client !== 2'd1) bad++;
      adv();
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL bp_hold: %0d stalled cycles changed state, expected 0", bad);
    end
    in_enque_ready = 1'b1;
    #1;
    n_cmp++;
    if (out_enque_en !== 1'b1 || out_enque_value !== W'(7) || in_req_ready !== 4'b0100) begin
      n_bad++;
      $display("FAIL bp_release: en=%b value=%0d ready=%b expected 1/7/0100", out_enque_en, out_enque_value, in_req_ready);
    end
    adv();
    in_req_valid = '0;
    #1;
    n_cmp++;
    if (out_enque_en !== 1'b1 || out_enque_client !== 2'd2 ||
        out_enque_value !== W'(102) || out_enque_count !== 32'd9) begin
      n_bad++;
      $display("FAIL bp_next: en=%b client=%0d value=%0d count=%0d expected 1/2/102/9",
               out_enque_en, out_enque_client, out_enque_value, out_enque_count);
    end
    adv();
  endtask

  task automatic test_headroom();
    int bad;
    heap_size    = SAW'(126);
    in_req_valid = 4'b0001;
    set_client(0, W'(55), PAW'(3));
    #1;
    n_cmp++;
    if (in_req_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL hr_accept: ready=%b expected 0001", in_req_ready);
    end
    adv();
    in_req_valid = '0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (out_enque_en !== 1'b0 || out_enque_value !== W'(55)) bad++;
      adv();
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL hr_block: %0d cycles issued at size 126, expected 0", bad);
    end
    heap_size = SAW'(125);
    #1;
    n_cmp++;
    if (out_enque_en !== 1'b1 || out_enque_value !== W'(55)) begin
      n_bad++;
      $display("FAIL hr_release: en=%b value=%0d expected 1/55", out_enque_en, out_enque_value);
    end
    adv();
    heap_size = '0;
  endtask

  task automatic test_async_reset();
    in_req_valid = '1;
    for (int c = 0; c < N; c++) set_client(c, W'(200 + c), PAW'(c));
    repeat (3) adv();
    #1;
    n_cmp++;
    if (out_enque_en !== 1'b1 || out_enque_count !== m_count) begin
      n_bad++;
      $display("FAIL ar_pre: en=%b count=%0d expected 1/%0d", out_enque_en, out_enque_count, m_count);
    end
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (out_enque_en !== 1'b0 || out_enque_count !== 32'd0 || in_req_ready !== '0) begin
      n_bad++;
      $display("FAIL ar_immediate: en=%b count=%0d ready=%b expected 0/0/0000",
               out_enque_en, out_enque_count, in_req_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    adv();
    #1;
    n_cmp++;
    if (in_req_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL ar_first_grant: ready=%b expected 0001", in_req_ready);
    end
    adv();
    in_req_valid = '0;
    repeat (2) adv();
  endtask

  task automatic test_single_client();
    int vi, fires, first, last;
    do_reset();
    heap_ready     = 1'b1;
    in_enque_ready = 1'b1;
    heap_size      = '0;
    vi = 0; fires = 0; first = -1; last = -1;
    for (int cyc = 0; cyc < 60 && fires < 32; cyc++) begin
      in_req_valid = (vi < 32) ? 4'b0100 : 4'b0000;
      set_client(2, W'(vi), PAW'(7));
      #1;
      model_eval();
      n_cmp++;
      if (in_req_ready !== e_ready || out_enque_en !== e_fire) begin
        n_bad++;
        $display("FAIL sc_ctl: ready=%b en=%b expected %b/%b", in_req_ready, out_enque_en, e_ready, e_fire);
      end
      if (out_enque_en === 1'b1) begin
        n_cmp++;
        if (out_enque_client !== 2'd2 || out_enque_value !== W'(fires)) begin
          n_bad++;
          $display("FAIL sc_order: client=%0d value=%0d expected 2/%0d", out_enque_client, out_enque_value, fires);
        end
        if (first < 0) first = cyc;
        last = cyc;
        fires++;
      end
      if (in_req_ready[2] === 1'b1) vi++;
      adv();
    end
    in_req_valid = '0;
    n_cmp++;
    if (fires != 32 || last - first != 31 || out_enque_count !== 32'd32) begin
      n_bad++;
      $display("FAIL sc_total: fires=%0d span=%0d count=%0d expected 32/31/32", fires, last - first, out_enque_count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_req_valid = N'($urandom);
      for (int c = 0; c < N; c++) set_client(c, {$urandom, $urandom}, PAW'($urandom_range(0, 1023)));
      heap_ready     = ($urandom_range(0, 9) != 0);
      in_enque_ready = ($urandom_range(0, 3) != 0);
      heap_size      = SAW'($urandom_range(120, 127));
      #1;
      model_eval();
      n_cmp++;
      if (in_req_ready !== e_ready || out_enque_en !== e_fire || out_enque_count !== m_count) begin
        n_bad++;
        $display("FAIL rnd_ctl[%0d]: ready=%b en=%b count=%0d expected %b/%b/%0d",
                 i, in_req_ready, out_enque_en, out_enque_count, e_ready, e_fire, m_count);
      end
      if (m_held) begin
        n_cmp++;
        if (out_enque_value !== m_val || out_enque_priority !== m_pri || out_enque_client !== CW'(m_cli)) begin
          n_bad++;
          $display("FAIL rnd_hold[%0d]: value=%0h prio=%0d client=%0d expected %0h/%0d/%0d",
                   i, out_enque_value, out_enque_priority, out_enque_client, m_val, m_pri, m_cli);
        end
      end
      adv();
    end
    in_req_valid = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_init_gate();
    test_round_robin();
    test_backpressure();
    test_headroom();
    test_async_reset();
    test_single_client();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
